// File: rtl/unidade_controle_exp7_pkg.sv
// Shared definitions for the experiment-7 game: state codes used by the
// control unit, the datapath debug displays and the bench.
package unidade_controle_exp7_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_INICIAL        = 4'h0,
    ST_PREPARACAO     = 4'h1,
    ST_INICIA_RODADA  = 4'h2,
    ST_ESPERA_JOGADA  = 4'h3,
    ST_REGISTRA       = 4'h4,
    ST_COMPARACAO     = 4'h5,
    ST_PROXIMO        = 4'h6,
    ST_ULTIMA_RODADA  = 4'h7,
    ST_PROXIMA_RODADA = 4'h8,
    ST_FIM_ACERTOU    = 4'hA,
    ST_FIM_TIMEOUT    = 4'hD,
    ST_FIM_ERROU      = 4'hE
  } state_t;

endpackage

// File: rtl/unidade_controle_exp7.sv
// Moore control unit for the memory game: sequences the rounds, drives the
// datapath counter/register strobes and reports the game outcome.
module unidade_controle_exp7
  import unidade_controle_exp7_pkg::*;
#(
  parameter int TIMEOUT_EN = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         iniciar,
  input  logic         jogada_feita,
  input  logic         igual,
  input  logic         endIgualRod,
  input  logic         fimRod,
  input  logic         fimT,
  input  logic         fimE,
  output logic         zeraE,
  output logic         contaE,
  output logic         zeraRod,
  output logic         contaRod,
  output logic         zeraT,
  output logic         contaT,
  output logic         zeraR,
  output logic         registraR,
  output logic         pronto,
  output logic         acertou,
  output logic         errou,
  output logic         timeout,
  output logic [3:0]   db_estado
);

  state_t state;
  state_t next_state;
  logic   unused_fim_e;

  assign unused_fim_e = fimE;

  always_comb begin
    next_state = ST_INICIAL;
    case (state)
      ST_INICIAL:        next_state = iniciar ? ST_PREPARACAO : ST_INICIAL;
      ST_PREPARACAO:     next_state = ST_INICIA_RODADA;
      ST_INICIA_RODADA:  next_state = ST_ESPERA_JOGADA;
      // A play arriving in the same cycle as the timeout still counts.
      ST_ESPERA_JOGADA: begin
        if (jogada_feita)                  next_state = ST_REGISTRA;
        else if (fimT && TIMEOUT_EN != 0)  next_state = ST_FIM_TIMEOUT;
        else                               next_state = ST_ESPERA_JOGADA;
      end
      ST_REGISTRA:       next_state = ST_COMPARACAO;
      ST_COMPARACAO: begin
        if (!igual)           next_state = ST_FIM_ERROU;
        else if (endIgualRod) next_state = ST_ULTIMA_RODADA;
        else                  next_state = ST_PROXIMO;
      end
      ST_PROXIMO:        next_state = ST_ESPERA_JOGADA;
      ST_ULTIMA_RODADA:  next_state = fimRod ? ST_FIM_ACERTOU : ST_PROXIMA_RODADA;
      ST_PROXIMA_RODADA: next_state = ST_INICIA_RODADA;
      ST_FIM_ACERTOU:    next_state = iniciar ? ST_PREPARACAO : ST_FIM_ACERTOU;
      ST_FIM_TIMEOUT:    next_state = iniciar ? ST_PREPARACAO : ST_FIM_TIMEOUT;
      ST_FIM_ERROU:      next_state = iniciar ? ST_PREPARACAO : ST_FIM_ERROU;
      default:           next_state = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_INICIAL;
    else       state <= next_state;
  end

  // Outputs depend on the state register only, so reset clears them at once.
  always_comb begin
    zeraE     = 1'b0;
    contaE    = 1'b0;
    zeraRod   = 1'b0;
    contaRod  = 1'b0;
    zeraT     = 1'b0;
    contaT    = 1'b0;
    zeraR     = 1'b0;
    registraR = 1'b0;
    pronto    = 1'b0;
    acertou   = 1'b0;
    errou     = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_PREPARACAO: begin
        zeraE   = 1'b1;
        zeraRod = 1'b1;
        zeraR   = 1'b1;
        zeraT   = 1'b1;
      end
      ST_INICIA_RODADA: begin
        zeraE = 1'b1;
        zeraT = 1'b1;
      end
      ST_ESPERA_JOGADA:  contaT = 1'b1;
      ST_REGISTRA: begin
        registraR = 1'b1;
        zeraT     = 1'b1;
      end
      ST_PROXIMO:        contaE = 1'b1;
      ST_PROXIMA_RODADA: contaRod = 1'b1;
      ST_FIM_ACERTOU: begin
        pronto  = 1'b1;
        acertou = 1'b1;
      end
      ST_FIM_TIMEOUT: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      ST_FIM_ERROU: begin
        pronto = 1'b1;
        errou  = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = state;

endmodule
